// File: rtl/event_router_mq.sv
// Event router: looks up incoming event numbers in a programmable routing table and
// dispatches them to per-bus output FIFOs, sticky status bits, or drop/unrouted counters.
module event_router_mq #(
   parameter int          EVNO_BITS   = 5,
   parameter int          COUNT_BITS  = 4,
   parameter int          OCOUNT_BITS = EVNO_BITS,
   parameter int          USER_BITS   = 4,
   parameter int          DISP_COUNT  = 2,
   parameter int          FIFO_BITS   = 2,
   parameter logic [14:0] DROP_MODE   = 15'd0
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic [31:0]                                  s_cer_data,
   input  logic                                         s_cer_valid,
   output logic                                         s_cer_ready,
   input  logic [EVNO_BITS-1:0]                         s_evno_data,
   input  logic                                         s_evno_valid,
   output logic                                         s_evno_ready,
   output logic [DISP_COUNT*COUNT_BITS-1:0]             mn_evno_data,
   output logic [DISP_COUNT*(OCOUNT_BITS+USER_BITS)-1:0] mn_evno_user,
   output logic [DISP_COUNT-1:0]                        mn_evno_valid,
   input  logic [DISP_COUNT-1:0]                        mn_evno_ready,
   output logic [(1<<EVNO_BITS)-1:0]                    status,
   output logic [DISP_COUNT*8-1:0]                      drop_cnt,
   output logic [7:0]                                   unrouted_cnt
);
   localparam int ENTRIES = 1 << EVNO_BITS;
   localparam int DEPTH   = 1 << FIFO_BITS;
   localparam int UW      = OCOUNT_BITS + USER_BITS;
   localparam int FW      = UW + COUNT_BITS;
   localparam logic [3:0] BUS_LIM    = 4'(DISP_COUNT);
   localparam logic [3:0] BUS_STATUS = 4'hF;

   typedef struct packed {
      logic                  en;
      logic [3:0]            bus;
      logic [USER_BITS-1:0]  user;
      logic [COUNT_BITS-1:0] disp;
   } entry_t;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t               state_q, state_d;
   logic [EVNO_BITS-1:0] init_cnt_q, init_cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_INIT;
         init_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      if (state_q == ST_INIT) begin
         init_cnt_d = init_cnt_q + EVNO_BITS'(1);
         if (init_cnt_q == EVNO_BITS'(ENTRIES-1)) state_d = ST_RUN;
      end
   end

   // Handshake rule for every stream port: a transfer happens on a rising edge where
   // valid and ready are both high; a source holds data stable while valid && !ready.
   logic                 run;
   logic                 cer_fire, evno_fire;
   logic [3:0]           cer_op;
   logic [EVNO_BITS-1:0] cer_idx;
   logic                 clr_all, clr_one;

   assign run         = (state_q == ST_RUN);
   assign s_cer_ready = run;
   assign cer_fire    = s_cer_valid && s_cer_ready;
   assign evno_fire   = s_evno_valid && s_evno_ready;
   assign cer_op      = s_cer_data[31:28];
   assign cer_idx     = s_cer_data[EVNO_BITS-1:0];
   assign clr_all     = cer_fire && (cer_op == 4'd1) && s_cer_data[27];
   assign clr_one     = cer_fire && (cer_op == 4'd1) && !s_cer_data[27];

   entry_t               table_q [ENTRIES];
   logic                 tbl_we;
   logic [EVNO_BITS-1:0] tbl_addr;
   entry_t               tbl_wdata;

   always_comb begin
      tbl_we    = 1'b0;
      tbl_addr  = cer_idx;
      tbl_wdata = '0;
      if (!run) begin
         tbl_we   = 1'b1;
         tbl_addr = init_cnt_q;
      end else if (cer_fire && cer_op == 4'd0) begin
         tbl_we         = 1'b1;
         tbl_wdata.en   = s_cer_data[26];
         tbl_wdata.bus  = s_cer_data[19:16];
         tbl_wdata.user = s_cer_data[20 +: USER_BITS];
         tbl_wdata.disp = s_cer_data[8 +: COUNT_BITS];
      end
   end

   always_ff @(posedge clk) begin
      if (tbl_we) table_q[tbl_addr] <= tbl_wdata;
   end

   // S1 stage: the lookup result lands here; a write to the same index at the same
   // edge is not visible until the next lookup.
   logic                 s1_valid_q;
   entry_t               s1_entry_q;
   logic [EVNO_BITS-1:0] s1_orig_q;
   logic                 s1_retire;
   logic                 route_bad, to_status;
   logic [DISP_COUNT-1:0] push, drop_inc, fifo_full, fifo_pop;
   logic [FW-1:0]        push_word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_entry_q <= '0;
         s1_orig_q  <= '0;
      end else if (evno_fire) begin
         s1_valid_q <= 1'b1;
         s1_entry_q <= table_q[s_evno_data];
         s1_orig_q  <= s_evno_data;
      end else if (s1_retire) begin
         s1_valid_q <= 1'b0;
      end
   end

   assign route_bad = !s1_entry_q.en ||
                      (s1_entry_q.bus >= BUS_LIM && s1_entry_q.bus != BUS_STATUS);
   assign to_status = s1_entry_q.en && (s1_entry_q.bus == BUS_STATUS);
   assign push_word = {s1_orig_q[OCOUNT_BITS-1:0], s1_entry_q.user, s1_entry_q.disp};

   always_comb begin
      push      = '0;
      drop_inc  = '0;
      s1_retire = 1'b0;
      if (s1_valid_q) begin
         if (route_bad || to_status) begin
            s1_retire = 1'b1;
         end else begin
            for (int b = 0; b < DISP_COUNT; b++) begin
               if (s1_entry_q.bus == 4'(b)) begin
                  if (!fifo_full[b] || fifo_pop[b]) begin
                     push[b]   = 1'b1;
                     s1_retire = 1'b1;
                  end else if (DROP_MODE[b]) begin
                     drop_inc[b] = 1'b1;
                     s1_retire   = 1'b1;
                  end
               end
            end
         end
      end
   end

   assign s_evno_ready = run && (!s1_valid_q || s1_retire);

   for (genvar g = 0; g < DISP_COUNT; g++) begin : g_bus
      logic [FW-1:0]        mem_q [DEPTH];
      logic [FIFO_BITS-1:0] wr_q, rd_q;
      logic [FIFO_BITS:0]   cnt_q;
      logic [FW-1:0]        head;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
         end else begin
            if (push[g])     wr_q <= wr_q + FIFO_BITS'(1);
            if (fifo_pop[g]) rd_q <= rd_q + FIFO_BITS'(1);
            case ({push[g], fifo_pop[g]})
               2'b10:   cnt_q <= cnt_q + (FIFO_BITS+1)'(1);
               2'b01:   cnt_q <= cnt_q - (FIFO_BITS+1)'(1);
               default: cnt_q <= cnt_q;
            endcase
         end
      end

      always_ff @(posedge clk) begin
         if (push[g]) mem_q[wr_q] <= push_word;
      end

      assign head             = mem_q[rd_q];
      assign mn_evno_valid[g] = (cnt_q != '0);
      assign fifo_full[g]     = (cnt_q == (FIFO_BITS+1)'(DEPTH));
      assign fifo_pop[g]      = mn_evno_valid[g] && mn_evno_ready[g];
      assign mn_evno_data[g*COUNT_BITS +: COUNT_BITS] = head[COUNT_BITS-1:0];
      assign mn_evno_user[g*UW +: UW]                 = head[FW-1:COUNT_BITS];
   end

   logic [ENTRIES-1:0]          status_q, status_d;
   logic [DISP_COUNT-1:0][7:0]  drop_q, drop_d;
   logic [7:0]                  unrouted_q, unrouted_d;

   // Clear-all beats a same-cycle increment; a status set beats a same-cycle clear.
   always_comb begin
      unrouted_d = unrouted_q;
      if (s1_valid_q && route_bad && unrouted_q != 8'hFF) unrouted_d = unrouted_q + 8'd1;
      if (clr_all) unrouted_d = '0;
      drop_d = drop_q;
      for (int b = 0; b < DISP_COUNT; b++) begin
         if (drop_inc[b] && drop_q[b] != 8'hFF) drop_d[b] = drop_q[b] + 8'd1;
      end
      if (clr_all) drop_d = '0;
      status_d = status_q;
      if (clr_all)      status_d          = '0;
      else if (clr_one) status_d[cer_idx] = 1'b0;
      if (s1_valid_q && to_status) status_d[s1_orig_q] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status_q   <= '0;
         drop_q     <= '0;
         unrouted_q <= '0;
      end else begin
         status_q   <= status_d;
         drop_q     <= drop_d;
         unrouted_q <= unrouted_d;
      end
   end

   assign status       = status_q;
   assign drop_cnt     = drop_q;
   assign unrouted_cnt = unrouted_q;

   logic unused_bits;
   assign unused_bits = ^{s_cer_data, s1_orig_q};
endmodule

// File: tb/tb_event_router_mq.sv
// Directed bench for event_router_mq: reset/INIT timing, routing, status, backpressure,
// drop saturation, read-first table update and mid-stream reset.
module tb_event_router_mq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] s_cer_data = '0;
   logic        s_cer_valid = 1'b0;
   logic        s_cer_ready;
   logic [4:0]  s_evno_data = '0;
   logic        s_evno_valid = 1'b0;
   logic        s_evno_ready;
   logic [7:0]  mn_evno_data;
   logic [17:0] mn_evno_user;
   logic [1:0]  mn_evno_valid;
   logic [1:0]  mn_evno_ready = 2'b00;
   logic [31:0] status;
   logic [15:0] drop_cnt;
   logic [7:0]  unrouted_cnt;

   int n_vec = 0;
   int n_err = 0;
   logic [12:0] exp_q0[$];
   logic [12:0] exp_q1[$];

   always #5 clk = ~clk;

   event_router_mq #(
      .EVNO_BITS(5), .COUNT_BITS(4), .OCOUNT_BITS(5), .USER_BITS(4),
      .DISP_COUNT(2), .FIFO_BITS(2), .DROP_MODE(15'd1)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_cer_data(s_cer_data), .s_cer_valid(s_cer_valid), .s_cer_ready(s_cer_ready),
      .s_evno_data(s_evno_data), .s_evno_valid(s_evno_valid), .s_evno_ready(s_evno_ready),
      .mn_evno_data(mn_evno_data), .mn_evno_user(mn_evno_user),
      .mn_evno_valid(mn_evno_valid), .mn_evno_ready(mn_evno_ready),
      .status(status), .drop_cnt(drop_cnt), .unrouted_cnt(unrouted_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] route_word(input int idx, input int disp, input int bus,
                                              input int user, input bit en);
      return (32'(en) << 26) | (32'(user & 63) << 20) | (32'(bus & 15) << 16) |
             (32'(disp & 255) << 8) | 32'(idx & 255);
   endfunction

   function automatic logic [12:0] exp_word(input int orig, input int user, input int disp);
      return {5'(orig), 4'(user), 4'(disp)};
   endfunction

   function automatic logic [12:0] bus_word(input int b);
      if (b == 0) return {mn_evno_user[8:0], mn_evno_data[3:0]};
      return {mn_evno_user[17:9], mn_evno_data[7:4]};
   endfunction

   task automatic cer_write(input logic [31:0] w);
      s_cer_valid = 1'b1;
      s_cer_data  = w;
      tick();
      s_cer_valid = 1'b0;
   endtask

   // Leaves s_evno_valid high so consecutive calls stream one event per cycle.
   task automatic send_ev(input int ev);
      bit done = 1'b0;
      s_evno_valid = 1'b1;
      s_evno_data  = 5'(ev);
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (s_evno_ready) done = 1'b1;
         tick();
      end
      if (!done) check("evno handshake", 32'(s_evno_ready), 32'd1);
   endtask

   task automatic ev_idle();
      s_evno_valid = 1'b0;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) begin
         if (mn_evno_valid[0] && mn_evno_ready[0]) begin
            if (exp_q0.size() == 0) check("bus0 extra push", 32'(mn_evno_valid[0]), 32'd0);
            else check("bus0 word", 32'(bus_word(0)), 32'(exp_q0.pop_front()));
         end
         if (mn_evno_valid[1] && mn_evno_ready[1]) begin
            if (exp_q1.size() == 0) check("bus1 extra push", 32'(mn_evno_valid[1]), 32'd0);
            else check("bus1 word", 32'(bus_word(1)), 32'(exp_q1.pop_front()));
         end
         tick();
      end
      check("bus0 pending", 32'(exp_q0.size()), 32'd0);
      check("bus1 pending", 32'(exp_q1.size()), 32'd0);
   endtask

   task automatic init_check();
      for (int i = 0; i < 31; i++) begin
         tick();
         check("init ready low", {30'd0, s_cer_ready, s_evno_ready}, 32'd0);
      end
      tick();
      check("run ready high", {30'd0, s_cer_ready, s_evno_ready}, 32'd3);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values and INIT length
      repeat (3) tick();
      check("rst valid", 32'(mn_evno_valid), 32'd0);
      check("rst status", status, 32'd0);
      check("rst drop", 32'(drop_cnt), 32'd0);
      check("rst unrouted", 32'(unrouted_cnt), 32'd0);
      check("rst ready", {30'd0, s_cer_ready, s_evno_ready}, 32'd0);
      rst_n = 1'b1;
      init_check();

      // Event before any configuration is unrouted
      send_ev(3);
      ev_idle();
      tick(); tick();
      check("unconfigured unrouted", 32'(unrouted_cnt), 32'd1);
      check("unconfigured valid", 32'(mn_evno_valid), 32'd0);

      // Basic route and latency
      cer_write(32'h0410_2A03);
      send_ev(3);
      ev_idle();
      check("latency N+1 valid", 32'(mn_evno_valid[0]), 32'd0);
      tick();
      check("latency N+2 valid", 32'(mn_evno_valid[0]), 32'd1);
      check("route word", 32'(bus_word(0)), 32'(exp_word(3, 1, 10)));
      tick();
      check("held word stable", 32'(bus_word(0)), 32'(exp_word(3, 1, 10)));
      mn_evno_ready = 2'b01;
      tick();
      check("popped valid", 32'(mn_evno_valid), 32'd0);

      // Status bus, clear, and set-beats-clear
      cer_write(route_word(7, 0, 15, 0, 1));
      send_ev(7);
      ev_idle();
      tick();
      check("status set", status, 32'h0000_0080);
      cer_write(32'h1000_0007);
      check("status clear", status, 32'd0);
      send_ev(7);
      ev_idle();
      cer_write(32'h1000_0007);
      check("status set wins", status, 32'h0000_0080);
      cer_write(32'h1000_0007);
      check("status clear again", status, 32'd0);

      // Out-of-range bus and disabled route are unrouted
      cer_write(route_word(30, 1, 5, 0, 1));
      cer_write(route_word(31, 1, 0, 0, 0));
      send_ev(30);
      send_ev(31);
      ev_idle();
      tick(); tick();
      check("invalid routes unrouted", 32'(unrouted_cnt), 32'd3);
      check("invalid routes no push", 32'(mn_evno_valid), 32'd0);

      // Backpressure on bus 1: 4 queued, 1 held in S1, then in-order drain
      for (int e = 8; e <= 12; e++) begin
         cer_write(route_word(e, e, 1, e - 8, 1));
         exp_q1.push_back(exp_word(e, e - 8, e));
      end
      mn_evno_ready = 2'b00;
      for (int e = 8; e <= 12; e++) send_ev(e);
      s_evno_data = 5'd13;
      tick();
      check("bp evno_ready low", 32'(s_evno_ready), 32'd0);
      check("bp bus1 valid", 32'(mn_evno_valid[1]), 32'd1);
      check("bp head word", 32'(bus_word(1)), 32'(exp_word(8, 0, 8)));
      check("bp no drops", 32'(drop_cnt), 32'd0);
      ev_idle();
      mn_evno_ready = 2'b10;
      drain(12);

      // Drop mode on bus 0: saturating counter and clear-all
      cer_write(route_word(20, 1, 0, 3, 1));
      mn_evno_ready = 2'b00;
      for (int i = 0; i < 300; i++) send_ev(20);
      ev_idle();
      tick(); tick();
      check("drop saturated", 32'(drop_cnt[7:0]), 32'd255);
      check("drop bus1 untouched", 32'(drop_cnt[15:8]), 32'd0);
      check("drop fifo valid", 32'(mn_evno_valid), 32'd1);
      for (int i = 0; i < 4; i++) exp_q0.push_back(exp_word(20, 3, 1));
      send_ev(20);
      ev_idle();
      cer_write(32'h1800_0000);
      check("clear-all drop", 32'(drop_cnt), 32'd0);
      check("clear-all unrouted", 32'(unrouted_cnt), 32'd0);
      mn_evno_ready = 2'b01;
      drain(8);

      // Full-rate stream with a same-edge route rewrite of event 3
      cer_write(route_word(4, 4, 1, 0, 1));
      mn_evno_ready = 2'b11;
      exp_q0.push_back(exp_word(3, 1, 10));
      exp_q0.push_back(exp_word(3, 1, 10));
      exp_q1.push_back(exp_word(4, 0, 4));
      exp_q1.push_back(exp_word(4, 0, 4));
      exp_q1.push_back(exp_word(3, 2, 5));
      exp_q1.push_back(exp_word(4, 0, 4));
      fork
         begin
            send_ev(3);
            send_ev(4);
            s_cer_data  = route_word(3, 5, 1, 2, 1);
            s_cer_valid = 1'b1;
            send_ev(3);
            s_cer_valid = 1'b0;
            send_ev(4);
            send_ev(3);
            send_ev(4);
            ev_idle();
         end
         drain(14);
      join

      // Mid-stream reset discards queued data and restarts INIT
      mn_evno_ready = 2'b00;
      send_ev(3);
      send_ev(4);
      ev_idle();
      tick();
      check("pre-reset queued", 32'(mn_evno_valid), 32'd2);
      rst_n = 1'b0;
      #1;
      check("reset valid", 32'(mn_evno_valid), 32'd0);
      check("reset ready", {30'd0, s_cer_ready, s_evno_ready}, 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      init_check();
      mn_evno_ready = 2'b11;
      send_ev(4);
      ev_idle();
      tick(); tick();
      check("table erased unrouted", 32'(unrouted_cnt), 32'd1);
      check("table erased no push", 32'(mn_evno_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
